// File: rtl/ysyx_220066_pkg.sv
// ysyx_220066_pkg: shared MemOp codes, write-back FSM states and defaults
package ysyx_220066_pkg;
    localparam int XLEN_DEF    = 64;
    localparam int TIMEOUT_DEF = 255;
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        RETIRE = 2'd2
    } wb_state_t;
endpackage

// File: rtl/ysyx_220066_load_ext.sv
// ysyx_220066_load_ext: aligns a load doubleword and sign/zero-extends it per MemOp
module ysyx_220066_load_ext
    import ysyx_220066_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      i_memop,
    input  logic [2:0]      i_addr,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_data,
    output logic            o_misalign
);
    logic [XLEN-1:0] w_raw;
    assign w_raw = i_rdata >> {i_addr, 3'b000};
    always_comb begin
        o_data = w_raw;
        case (i_memop)
            LB:      o_data = {{(XLEN-8){w_raw[7]}}, w_raw[7:0]};
            LH:      o_data = {{(XLEN-16){w_raw[15]}}, w_raw[15:0]};
            LW:      o_data = {{(XLEN-32){w_raw[31]}}, w_raw[31:0]};
            LD:      o_data = w_raw;
            LBU:     o_data = {{(XLEN-8){1'b0}}, w_raw[7:0]};
            LHU:     o_data = {{(XLEN-16){1'b0}}, w_raw[15:0]};
            LWU:     o_data = {{(XLEN-32){1'b0}}, w_raw[31:0]};
            default: o_data = w_raw;
        endcase
    end
    assign o_misalign = (i_memop == LH || i_memop == LHU) ? i_addr[0] :
                        (i_memop == LW || i_memop == LWU) ? |i_addr[1:0] :
                        (i_memop == LD) ? |i_addr : 1'b0;
endmodule

// File: rtl/ysyx_220066_wb.sv
// ysyx_220066_wb: write-back stage; waits for load data, extends it, writes rd and commits
module ysyx_220066_wb
    import ysyx_220066_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic            RegWr_in,
    input  logic            MemRd_in,
    input  logic            MemWr_in,
    input  logic            done_in,
    input  logic            error_in,
    input  logic [2:0]      MemOp_in,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] addr_in,
    input  logic [XLEN-1:0] nxtpc_in,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            block,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_nxtpc,
    output logic            commit_done,
    output logic            commit_error
);
    localparam int CW = $clog2(TIMEOUT + 2);
    wb_state_t       r_state, w_nstate;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic            r_regwr, r_done, r_err;
    logic [2:0]      r_memop, r_addr;
    logic [4:0]      r_rd, w_rd;
    logic [XLEN-1:0] r_nxtpc, w_ext, w_data, w_nxtpc;
    logic            w_acc, w_mis, w_lerr, w_cv, w_en, w_done, w_err;
    assign block  = (r_state == WAIT);
    assign w_acc  = valid_in && !block;
    assign w_lerr = r_err || w_mis || (r_memop == 3'b111);
    ysyx_220066_load_ext #(.XLEN(XLEN)) u_ext (
        .i_memop   (r_memop),
        .i_addr    (r_addr),
        .i_rdata   (mem_rdata),
        .o_data    (w_ext),
        .o_misalign(w_mis)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_cnt;
        end
    end
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_regwr <= RegWr_in;
            r_done  <= done_in;
            r_err   <= error_in;
            r_memop <= MemOp_in;
            r_addr  <= addr_in[2:0];
            r_rd    <= rd_in;
            r_nxtpc <= nxtpc_in;
        end
    end
    // next state plus the values the output registers take when it is RETIRE
    always_comb begin
        w_nstate = IDLE;
        w_cnt    = r_cnt;
        w_cv     = 1'b0;
        w_en     = 1'b0;
        w_rd     = wb_rd;
        w_data   = wb_data;
        w_nxtpc  = commit_nxtpc;
        w_done   = commit_done;
        w_err    = commit_error;
        if (r_state == WAIT) begin
            w_nstate = WAIT;
            w_cnt    = r_cnt + 1'b1;
            if (mem_rvalid || r_cnt == CW'(TIMEOUT)) begin
                w_nstate = RETIRE;
                w_cv     = 1'b1;
                w_rd     = r_rd;
                w_nxtpc  = r_nxtpc;
                w_done   = r_done;
                w_err    = !mem_rvalid || w_lerr;
                w_en     = r_regwr && |r_rd && !w_err;
                w_data   = mem_rvalid ? w_ext : wb_data;
            end
        end else if (w_acc) begin
            w_cnt    = '0;
            w_nstate = MemRd_in ? WAIT : RETIRE;
            if (!MemRd_in) begin
                w_cv    = 1'b1;
                w_rd    = rd_in;
                w_data  = addr_in;
                w_nxtpc = nxtpc_in;
                w_done  = done_in;
                w_err   = error_in;
                w_en    = RegWr_in && |rd_in && !error_in && !MemWr_in;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en        <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            commit_valid <= 1'b0;
            commit_nxtpc <= '0;
            commit_done  <= 1'b0;
            commit_error <= 1'b0;
        end else begin
            wb_en        <= w_en;
            wb_rd        <= w_rd;
            wb_data      <= w_data;
            commit_valid <= w_cv;
            commit_nxtpc <= w_nxtpc;
            commit_done  <= w_done;
            commit_error <= w_err;
        end
    end
endmodule

// File: tb/tb_ysyx_220066_wb.sv
// tb_ysyx_220066_wb: random and directed stimulus against a scoreboard of expected commits
module tb_ysyx_220066_wb;
    localparam int TIMEOUT = 255;
    typedef struct {
        logic [63:0] nxtpc;
        logic [63:0] data;
        logic [4:0]  rd;
        logic        done;
        logic        err;
        logic        en;
        int          cyc;
    } exp_t;

    logic        clk, rst, valid_in, RegWr_in, MemRd_in, MemWr_in, done_in, error_in, mem_rvalid;
    logic [2:0]  MemOp_in;
    logic [4:0]  rd_in;
    logic [63:0] addr_in, nxtpc_in, mem_rdata;
    logic        block, wb_en, commit_valid, commit_done, commit_error;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data, commit_nxtpc;

    exp_t        q[$];
    exp_t        me;
    int          n_chk = 0, n_err = 0, cyc = 0;
    bit          m_act = 0, m_to = 0;
    int          m_k = 0, m_d = 0;
    logic [63:0] m_rdv;

    ysyx_220066_wb #(.XLEN(64), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .RegWr_in(RegWr_in), .MemRd_in(MemRd_in),
        .MemWr_in(MemWr_in), .done_in(done_in), .error_in(error_in), .MemOp_in(MemOp_in),
        .rd_in(rd_in), .addr_in(addr_in), .nxtpc_in(nxtpc_in), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .block(block), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .commit_valid(commit_valid), .commit_nxtpc(commit_nxtpc), .commit_done(commit_done),
        .commit_error(commit_error)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference load: byte-lane select, then mask to size and optionally sign-fill
    function automatic void model_load(input logic [2:0] op, input logic [63:0] a, input logic [63:0] rdata,
                                       output logic [63:0] v, output bit bad);
        int sz;
        logic [63:0] raw, mask;
        sz   = 1 << op[1:0];
        raw  = rdata >> (8 * int'(a[2:0]));
        mask = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
        v    = raw & mask;
        if (!op[2] && sz < 8 && raw[8*sz-1]) v = v | ~mask;
        bad  = (op == 3'b111) || (int'(a[2:0]) % sz != 0);
    endfunction

    // one call per falling edge: check block against the outstanding-load model and drive memory
    task automatic mem_tick();
        chk("block", block, m_act);
        if (m_act) begin
            mem_rvalid = (!m_to && m_k == m_d);
            mem_rdata  = mem_rvalid ? m_rdv : {$urandom, $urandom};
            m_k++;
            if (mem_rvalid || (m_to && m_k == TIMEOUT + 1)) m_act = 0;
        end else begin
            mem_rvalid = ($urandom_range(3) == 0);
            mem_rdata  = {$urandom, $urandom};
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            valid_in = 0;
            mem_tick();
            @(negedge clk);
        end
    endtask

    task automatic issue(input logic rw, input logic mr, input logic mw, input logic dn, input logic er,
                         input logic [2:0] op, input logic [4:0] rd, input logic [63:0] addr,
                         input logic [63:0] pc, input int d, input bit to, input logic [63:0] rdata,
                         input bit drop);
        exp_t e;
        logic [63:0] v;
        bit bad;
        valid_in = 1; RegWr_in = rw; MemRd_in = mr; MemWr_in = mw; done_in = dn; error_in = er;
        MemOp_in = op; rd_in = rd; addr_in = addr; nxtpc_in = pc;
        for (int i = 0; i < 400; i++) begin
            mem_tick();
            if (!block) begin
                e.nxtpc = pc;
                e.done  = dn;
                e.rd    = rd;
                if (mr) begin
                    model_load(op, addr, rdata, v, bad);
                    e.err  = er || bad || to;
                    e.data = v;
                    e.cyc  = cyc + (to ? TIMEOUT + 2 : d + 2);
                    m_act = 1; m_k = 0; m_d = d; m_to = to; m_rdv = rdata;
                end else begin
                    e.err  = er;
                    e.data = addr;
                    e.cyc  = cyc + 1;
                end
                e.en = rw && !mw && rd != 0 && !e.err;
                if (!drop) q.push_back(e);
                @(negedge clk);
                valid_in = 0;
                return;
            end
            @(negedge clk);
        end
        chk("accept_timeout", 0, 1);
        valid_in = 0;
    endtask

    // monitor: compare every presented commit with the head of the scoreboard
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (commit_valid) begin
                if (q.size() == 0) chk("spurious_commit", 1, 0);
                else begin
                    me = q.pop_front();
                    chk("commit_cycle", cyc, me.cyc);
                    chk("commit_nxtpc", commit_nxtpc, me.nxtpc);
                    chk("commit_done", commit_done, me.done);
                    chk("commit_error", commit_error, me.err);
                    chk("wb_en", wb_en, me.en);
                    if (me.en) begin
                        chk("wb_rd", wb_rd, me.rd);
                        chk("wb_data", wb_data, me.data);
                    end
                end
            end else if (wb_en) chk("wb_en_no_commit", wb_en, 0);
        end
    end

    initial begin
        int k, n_to;
        logic [4:0] rd;
        logic [2:0] op;
        logic [63:0] addr, pc;
        rst = 1; valid_in = 0; RegWr_in = 0; MemRd_in = 0; MemWr_in = 0; done_in = 0; error_in = 0;
        MemOp_in = 0; rd_in = 0; addr_in = 0; nxtpc_in = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_block", block, 0);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_commit_nxtpc", commit_nxtpc, 0);
        chk("rst_commit_done", commit_done, 0);
        chk("rst_commit_error", commit_error, 0);
        rst = 0;
        issue(1, 0, 0, 0, 0, 3'b000, 5'd5, 64'h1234, 64'h8000_0004, 0, 0, 64'h0, 0);
        issue(1, 1, 0, 0, 0, 3'b000, 5'd6, 64'h8000_0003, 64'h8000_0008, 2, 0, 64'h0000_0000_8000_0000, 0);
        issue(1, 1, 0, 0, 0, 3'b110, 5'd7, 64'h8000_0004, 64'h8000_000C, 1, 0, 64'hDEAD_BEEF_0000_0000, 0);
        issue(1, 1, 0, 0, 0, 3'b010, 5'd8, 64'h8000_0004, 64'h8000_0010, 0, 0, 64'hDEAD_BEEF_0000_0000, 0);
        issue(1, 1, 0, 0, 0, 3'b011, 5'd9, 64'h8000_0002, 64'h8000_0014, 1, 0, 64'h1122_3344_5566_7788, 0);
        issue(1, 1, 0, 0, 0, 3'b011, 5'd10, 64'h8000_0008, 64'h8000_0018, 0, 1, 64'h0, 0);
        issue(1, 0, 0, 0, 0, 3'b000, 5'd0, 64'h55, 64'h8000_001C, 0, 0, 64'h0, 0);
        issue(1, 0, 0, 1, 0, 3'b000, 5'd11, 64'h66, 64'h8000_0020, 0, 0, 64'h0, 0);
        issue(1, 0, 1, 0, 0, 3'b011, 5'd12, 64'h77, 64'h8000_0024, 0, 0, 64'h0, 0);
        idle(2);
        n_to = 0;
        for (int n = 0; n < 250; n++) begin
            k    = $urandom_range(9);
            rd   = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            addr = {$urandom, $urandom};
            pc   = {$urandom, $urandom};
            if (k < 4)
                issue($urandom_range(4) != 0, 0, 0, $urandom_range(15) == 0, $urandom_range(15) == 0,
                      3'($urandom_range(7)), rd, addr, pc, 0, 0, 64'h0, 0);
            else if (k < 6)
                issue($urandom_range(1) == 1, 0, 1, 0, 0, 3'($urandom_range(7)), rd, addr, pc, 0, 0, 64'h0, 0);
            else begin
                op = 3'($urandom_range(7));
                if ($urandom_range(3) != 0) addr[2:0] = 3'($urandom_range(7)) & ~3'((1 << op[1:0]) - 1);
                issue($urandom_range(4) != 0, 1, 0, 0, $urandom_range(15) == 0, op, rd, addr, pc,
                      $urandom_range(5), (n_to < 3 && $urandom_range(40) == 0), {$urandom, $urandom}, 0);
                if (m_to) n_to++;
            end
            if ($urandom_range(3) == 0) idle($urandom_range(2));
        end
        for (int i = 0; i < 400 && q.size() != 0; i++) idle(1);
        chk("drain_before_reset", q.size(), 0);
        issue(1, 1, 0, 0, 0, 3'b011, 5'd9, 64'h1000, 64'h8000_1000, 0, 1, 64'h0, 1);
        idle(3);
        rst = 1; m_act = 0; mem_rvalid = 0;
        @(negedge clk);
        rst = 0; mem_rvalid = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        chk("post_rst_block", block, 0);
        chk("post_rst_wb_en", wb_en, 0);
        chk("post_rst_wb_rd", wb_rd, 0);
        chk("post_rst_wb_data", wb_data, 0);
        chk("post_rst_commit_valid", commit_valid, 0);
        chk("post_rst_commit_nxtpc", commit_nxtpc, 0);
        chk("post_rst_commit_done", commit_done, 0);
        chk("post_rst_commit_error", commit_error, 0);
        @(negedge clk);
        mem_rvalid = 0;
        chk("late_rvalid_commit", commit_valid, 0);
        chk("late_rvalid_block", block, 0);
        idle(5);
        issue(1, 0, 0, 0, 0, 3'b000, 5'd3, 64'hABCD, 64'h8000_2000, 0, 0, 64'h0, 0);
        idle(4);
        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
